// File: rtl/shift_pkg.sv
// Shared encodings for the ARM shifter-operand datapath.
package shift_pkg;

  // Width of a register-specified shift amount (Rs[7:0]).
  localparam int unsigned AMT_W_REG = 8;
  // Width of an immediate shift amount and of the barrel shifter amount port.
  localparam int unsigned AMT_W_IMM = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RF_WAIT = 2'b01,
    HOLD    = 2'b10
  } state_e;

endpackage

// File: rtl/shift.sv
// Single-function barrel shifter. Amount 0 passes the operand and carry through;
// amounts 1..31 follow ARM semantics. Out-of-range and #0 encodings are handled
// by the caller.
module shift
  import shift_pkg::*;
#(
  parameter shift_type_e SHIFT_TYPE = SH_LSL,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_op,
  input  logic [AMT_W_IMM-1:0]  i_amount,
  input  logic                  i_carry,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry
);

  logic [DATA_WIDTH:0]  ext;
  logic [AMT_W_IMM-1:0] inv_amt;

  // Shift with the carry bit carried along in a one-bit extension of the operand.
  always_comb begin
    ext      = '0;
    inv_amt  = '0 - i_amount;
    o_result = i_op;
    o_carry  = i_carry;
    if (i_amount != '0) begin
      case (SHIFT_TYPE)
        SH_LSL: begin
          ext      = {1'b0, i_op} << i_amount;
          o_result = ext[DATA_WIDTH-1:0];
          o_carry  = ext[DATA_WIDTH];
        end
        SH_LSR: begin
          ext      = {i_op, 1'b0} >> i_amount;
          o_result = ext[DATA_WIDTH:1];
          o_carry  = ext[0];
        end
        SH_ASR: begin
          ext      = $signed({i_op, 1'b0}) >>> i_amount;
          o_result = ext[DATA_WIDTH:1];
          o_carry  = ext[0];
        end
        SH_ROR: begin
          o_result = (i_op >> i_amount) | (i_op << inv_amt);
          o_carry  = o_result[DATA_WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_ctrl.sv
// ARMv4 data-processing shifter operand sequencer: accepts a shift request,
// fetches Rs for register-specified shifts, applies the ARM special-case
// encodings and returns a registered result/carry over valid/ready.
module shift_operand_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RF_IDX_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_type,
  input  logic                    i_reg_shift,
  input  logic [4:0]              i_imm_amount,
  input  logic [RF_IDX_WIDTH-1:0] i_rs_idx,
  input  logic [DATA_WIDTH-1:0]   i_op,
  input  logic                    i_carry,
  output logic                    o_rf_req,
  output logic [RF_IDX_WIDTH-1:0] o_rf_idx,
  input  logic                    i_rf_gnt,
  input  logic [DATA_WIDTH-1:0]   i_rf_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic                    o_carry
);

  localparam logic [AMT_W_REG-1:0] AMT_FULL = AMT_W_REG'(DATA_WIDTH);

  state_e                 state;
  shift_type_e            lat_type;
  logic [DATA_WIDTH-1:0]  lat_op;
  logic                   lat_carry;

  logic                   accept;
  logic                   sel_live;
  shift_type_e            cur_type;
  logic [DATA_WIDTH-1:0]  cur_op;
  logic                   cur_c;
  logic                   cur_reg;
  logic [AMT_W_REG-1:0]   cur_amt;

  logic [DATA_WIDTH-1:0]  sh_result [4];
  logic                   sh_carry  [4];
  logic [DATA_WIDTH-1:0]  nxt_result;
  logic                   nxt_carry;

  // Only the shift amount byte of Rs is meaningful.
  logic unused_rf_hi;
  assign unused_rf_hi = ^i_rf_data[DATA_WIDTH-1:AMT_W_REG];

  assign accept = i_valid && o_ready;

  // Request acceptance: free in IDLE, tied to result consumption in HOLD.
  always_comb begin
    o_ready = 1'b0;
    case (state)
      IDLE:    o_ready = 1'b1;
      RF_WAIT: o_ready = 1'b0;
      HOLD:    o_ready = i_ready;
      default: o_ready = 1'b0;
    endcase
  end

  // Operand source: live request inputs when accepting, latched request plus
  // granted Rs byte while waiting on the register file.
  always_comb begin
    sel_live = (state != RF_WAIT);
    cur_type = sel_live ? shift_type_e'(i_type) : lat_type;
    cur_op   = sel_live ? i_op : lat_op;
    cur_c    = sel_live ? i_carry : lat_carry;
    cur_reg  = !sel_live;
    cur_amt  = sel_live ? {{(AMT_W_REG-AMT_W_IMM){1'b0}}, i_imm_amount}
                        : i_rf_data[AMT_W_REG-1:0];
  end

  shift #(.SHIFT_TYPE(SH_LSL), .DATA_WIDTH(DATA_WIDTH)) u_shift_lsl (
    .i_op(cur_op), .i_amount(cur_amt[AMT_W_IMM-1:0]), .i_carry(cur_c),
    .o_result(sh_result[0]), .o_carry(sh_carry[0])
  );

  shift #(.SHIFT_TYPE(SH_LSR), .DATA_WIDTH(DATA_WIDTH)) u_shift_lsr (
    .i_op(cur_op), .i_amount(cur_amt[AMT_W_IMM-1:0]), .i_carry(cur_c),
    .o_result(sh_result[1]), .o_carry(sh_carry[1])
  );

  shift #(.SHIFT_TYPE(SH_ASR), .DATA_WIDTH(DATA_WIDTH)) u_shift_asr (
    .i_op(cur_op), .i_amount(cur_amt[AMT_W_IMM-1:0]), .i_carry(cur_c),
    .o_result(sh_result[2]), .o_carry(sh_carry[2])
  );

  shift #(.SHIFT_TYPE(SH_ROR), .DATA_WIDTH(DATA_WIDTH)) u_shift_ror (
    .i_op(cur_op), .i_amount(cur_amt[AMT_W_IMM-1:0]), .i_carry(cur_c),
    .o_result(sh_result[3]), .o_carry(sh_carry[3])
  );

  // Select the shifter for the requested type, then override the ARM #0 and
  // out-of-range encodings the 5-bit shifter cannot express.
  always_comb begin
    nxt_result = sh_result[cur_type];
    nxt_carry  = sh_carry[cur_type];
    if (!cur_reg) begin
      if (cur_amt == '0) begin
        case (cur_type)
          SH_LSL: begin
            nxt_result = cur_op;
            nxt_carry  = cur_c;
          end
          SH_LSR: begin
            nxt_result = '0;
            nxt_carry  = cur_op[DATA_WIDTH-1];
          end
          SH_ASR: begin
            nxt_result = {DATA_WIDTH{cur_op[DATA_WIDTH-1]}};
            nxt_carry  = cur_op[DATA_WIDTH-1];
          end
          SH_ROR: begin
            nxt_result = {cur_c, cur_op[DATA_WIDTH-1:1]};
            nxt_carry  = cur_op[0];
          end
          default: ;
        endcase
      end
    end else if (cur_amt == '0) begin
      nxt_result = cur_op;
      nxt_carry  = cur_c;
    end else if (cur_type == SH_ROR) begin
      if (cur_amt[AMT_W_IMM-1:0] == '0) begin
        nxt_result = cur_op;
        nxt_carry  = cur_op[DATA_WIDTH-1];
      end
    end else if (cur_amt >= AMT_FULL) begin
      case (cur_type)
        SH_LSL: begin
          nxt_result = '0;
          nxt_carry  = (cur_amt == AMT_FULL) && cur_op[0];
        end
        SH_LSR: begin
          nxt_result = '0;
          nxt_carry  = (cur_amt == AMT_FULL) && cur_op[DATA_WIDTH-1];
        end
        SH_ASR: begin
          nxt_result = {DATA_WIDTH{cur_op[DATA_WIDTH-1]}};
          nxt_carry  = cur_op[DATA_WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered result, valid and register-file request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_rf_req  <= 1'b0;
      o_rf_idx  <= '0;
      o_result  <= '0;
      o_carry   <= 1'b0;
      lat_type  <= SH_LSL;
      lat_op    <= '0;
      lat_carry <= 1'b0;
    end else begin
      case (state)
        RF_WAIT: begin
          if (i_rf_gnt) begin
            o_result <= nxt_result;
            o_carry  <= nxt_carry;
            o_valid  <= 1'b1;
            o_rf_req <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: ;
      endcase
      // Acceptance (IDLE, or HOLD while the result drains) overrides the
      // state-local updates above so back-to-back requests skip IDLE.
      if (accept) begin
        lat_type  <= shift_type_e'(i_type);
        lat_op    <= i_op;
        lat_carry <= i_carry;
        if (i_reg_shift) begin
          o_rf_req <= 1'b1;
          o_rf_idx <= i_rs_idx;
          o_valid  <= 1'b0;
          state    <= RF_WAIT;
        end else begin
          o_result <= nxt_result;
          o_carry  <= nxt_carry;
          o_valid  <= 1'b1;
          state    <= HOLD;
        end
      end
    end
  end

endmodule
